// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one mac_unit between NUM_REQ requesters.
// Define MAC_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles and report rsp_err.
module mac_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAC        = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MAC-1:0]     req_a,
  input  logic [NUM_REQ*MAC-1:0]     req_b,
  input  logic [NUM_REQ-1:0]         req_clear,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_acc,
  output logic                       rsp_err,
  output logic                       mac_start,
  output logic                       mac_clear,
  output logic [MAC-1:0]             mac_a,
  output logic [MAC-1:0]             mac_b,
  input  logic [DATA_WIDTH-1:0]      mac_acc,
  input  logic                       mac_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int          IW = $clog2(NUM_REQ);
  localparam int unsigned N  = NUM_REQ;

  if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("mac_rr_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                  state_q;
  logic [IW-1:0]           ptr_q;
  logic [IW-1:0]           grant_q;
  logic [MAC-1:0]          op_a_q;
  logic [MAC-1:0]          op_b_q;
  logic                    op_clr_q;
  logic                    start_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [IW-1:0]           win;
  logic                    any_valid;
  int unsigned             idx;
`ifdef MAC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
`endif

  // Rotating priority search starting at ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid && !rst) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_clr_q    <= 1'b0;
      start_q     <= 1'b0;
      res_q       <= '0;
      rsp_valid_q <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (any_valid) begin
          grant_q  <= win;
          op_a_q   <= req_a[32'(win)*MAC +: MAC];
          op_b_q   <= req_b[32'(win)*MAC +: MAC];
          op_clr_q <= req_clear[win];
          start_q  <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: begin
`ifdef MAC_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (mac_done) begin
            res_q       <= mac_acc;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= RESP;
`ifdef MAC_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
          // Compare against TIMEOUT-1: the counter would reach TIMEOUT on this edge.
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
`endif
          end
        end
        RESP: if (rsp_ready[grant_q]) begin
          rsp_valid_q <= '0;
          ptr_q       <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_acc   = res_q;
  assign mac_start = start_q;
  assign mac_clear = start_q & op_clr_q;
  assign mac_a     = op_a_q;
  assign mac_b     = op_b_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
`ifdef MAC_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Bench for mac_rr_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mac_rr_arbiter;
  localparam int N = 4, MW = 8, DW = 32, TO = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, req_clear, rsp_valid, rsp_ready;
  logic [N*MW-1:0] req_a, req_b;
  logic [DW-1:0] rsp_acc, mac_acc;
  logic rsp_err, mac_start, mac_clear, mac_done, busy;
  logic [MW-1:0] mac_a, mac_b;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  mac_rr_arbiter #(.NUM_REQ(N), .MAC(MW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_clear(req_clear), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc),
    .rsp_err(rsp_err), .mac_start(mac_start), .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .mac_done(mac_done), .busy(busy), .grant_id(grant_id));

  int errors = 0, checks = 0, cyc = 0;
  bit chk_en = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in mac_unit: done pulse mac_lat cycles after start, never if mac_hang.
  int mac_lat = 1, fu_cnt;
  bit mac_hang = 0;
  logic stray_done = 1'b0, fu_done;
  logic [DW-1:0] fu_acc;
  assign mac_done = fu_done | stray_done;
  assign mac_acc  = fu_acc;
  always @(posedge clk) begin
    fu_done <= 1'b0;
    if (rst) begin
      fu_cnt <= 0; fu_acc <= '0;
    end else if (mac_start) begin
      fu_acc <= (mac_clear ? '0 : fu_acc) + DW'(mac_a) * DW'(mac_b);
      if (!mac_hang) begin
        if (mac_lat == 1) fu_done <= 1'b1; else fu_cnt <= mac_lat - 1;
      end
    end else if (fu_cnt > 0) begin
      if (fu_cnt == 1) fu_done <= 1'b1;
      fu_cnt <= fu_cnt - 1;
    end
  end

  // Reference model: phase 0 idle, 1 start pulse, 2 waiting on the unit, 3 responding.
  int m_phase, m_ptr, m_gid, m_cnt, m_win;
  logic [MW-1:0] m_a, m_b;
  logic m_clr, m_err;
  logic [DW-1:0] m_res;
  logic [N-1:0] e_rdy, e_rv;

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    int best = -1, bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - ptr + N) % N) < bd) begin bd = (i - ptr + N) % N; best = i; end
    return best;
  endfunction

  always_comb begin
    m_win = winner(req_valid, m_ptr);
    e_rdy = '0;
    e_rv  = '0;
    if (m_phase == 0 && !rst && m_win >= 0) e_rdy[m_win] = 1'b1;
    if (m_phase == 3) e_rv[m_gid] = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 0; m_gid <= 0; m_cnt <= 0;
      m_a <= '0; m_b <= '0; m_clr <= 1'b0; m_res <= '0; m_err <= 1'b0;
    end else case (m_phase)
      0: if (m_win >= 0) begin
        m_gid <= m_win; m_a <= req_a[m_win*MW +: MW]; m_b <= req_b[m_win*MW +: MW];
        m_clr <= req_clear[m_win]; m_phase <= 1;
      end
      1: begin m_phase <= 2; m_cnt <= 0; end
      2: begin
        if (mac_done) begin m_res <= mac_acc; m_err <= 1'b0; m_phase <= 3; end
`ifdef MAC_ARB_TIMEOUT_EN
        else if (m_cnt + 1 >= TO) begin m_res <= '0; m_err <= 1'b1; m_phase <= 3; end
`endif
        else m_cnt <= m_cnt + 1;
      end
      default: if (rsp_ready[m_gid]) begin m_ptr <= (m_gid + 1) % N; m_phase <= 0; end
    endcase
  end

  int gq[$], gc[$];
  always @(negedge clk) if (chk_en) begin
    check("req_ready", req_ready, e_rdy);
    check("busy", busy, m_phase != 0);
    check("grant_id", grant_id, m_gid);
    check("mac_start", mac_start, m_phase == 1);
    check("mac_clear", mac_clear, m_phase == 1 && m_clr);
    check("mac_a", mac_a, m_a);
    check("mac_b", mac_b, m_b);
    check("rsp_valid", rsp_valid, e_rv);
    if (m_phase == 3) begin
      check("rsp_acc", rsp_acc, m_res);
      check("rsp_err", rsp_err, m_err);
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin gq.push_back(i); gc.push_back(cyc); end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_req(input int i, input logic v, input int a, input int b, input logic c);
    req_valid[i] = v; req_a[i*MW +: MW] = MW'(a); req_b[i*MW +: MW] = MW'(b); req_clear[i] = c;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    #1;
    while (req_ready[i] !== 1'b1 && n < 40) begin tick(); #1; n++; end
    check($sformatf("grant_req%0d", i), req_ready[i], 1'b1);
    tick();
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (rsp_valid[i] !== 1'b1 && n < 60) begin tick(); n++; end
    check($sformatf("rsp_req%0d", i), rsp_valid[i], 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin tick(); n++; end
    check("return_idle", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);            check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);  check({tag, "_mac_start"}, mac_start, 0);
    check({tag, "_mac_clear"}, mac_clear, 0);  check({tag, "_mac_a"}, mac_a, 0);
    check({tag, "_mac_b"}, mac_b, 0);          check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_rsp_acc"}, rsp_acc, 0);      check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    int n;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    req_valid = '0; req_a = '0; req_b = '0; req_clear = '0; rsp_ready = '1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0; chk_en = 1;

    // Reset while waiting on the unit: no response, everything back to zero.
    mac_hang = 1;
    set_req(0, 1, 3, 4, 1);
    wait_grant(0); req_valid[0] = 1'b0;
    check("issue_start", mac_start, 1); check("issue_clear", mac_clear, 1);
    tick(); tick();
    check("wait_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("midwait_rst");
    mac_hang = 0; mac_lat = 2;
    set_req(0, 1, 3, 4, 1);
    wait_grant(0); req_valid[0] = 1'b0;
    wait_rsp(0);
    check("rst_reissue_valid", rsp_valid, 4'b0001);
    check("rst_reissue_acc", rsp_acc, 12);
    check("rst_reissue_err", rsp_err, 0);
    tick();

    // Fairness with all requesters valid and k=1: 0,1,2,3,0 every 4 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    mac_lat = 1;
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 2 * i + 3, i == 0);
    gq.delete(); gc.delete();
    n = 0;
    while (gq.size() < 5 && n < 60) begin tick(); n++; end
    req_valid = '0;
    wait_idle();
    check("fair_count", gq.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("fair_grant%0d", k), gq[k], exp_seq[k]);
    for (int k = 1; k < 5; k++) check($sformatf("fair_gap%0d", k), gc[k] - gc[k-1], 4);

    // Requester 1 arrives after 2 is granted and still beats 2's re-request.
    gq.delete(); gc.delete();
    set_req(2, 1, 10, 10, 1);
    wait_grant(2);
    set_req(1, 1, 4, 5, 0);
    n = 0;
    while (gq.size() < 3 && n < 60) begin tick(); n++; end
    req_valid = '0;
    wait_idle();
    check("prio_count", gq.size(), 3);
    check("prio_g0", gq[0], 2); check("prio_g1", gq[1], 1); check("prio_g2", gq[2], 2);

    // Response backpressure on requester 1, stray done pulses in RESP and IDLE.
    rsp_ready = 4'b1101;
    set_req(1, 1, 7, 9, 1);
    wait_grant(1); req_valid[1] = 1'b0;
    set_req(3, 1, 5, 6, 0);
    wait_rsp(1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rsp_valid, 4'b0010);
      check("bp_acc", rsp_acc, 63);
      check("bp_no_ready", req_ready, 0);
      if (k == 2) stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
    end
    rsp_ready = '1;
    tick();
    stray_done = 1'b1; #1;
    check("bp_next_ready", req_ready, 4'b1000);
    tick(); stray_done = 1'b0; req_valid[3] = 1'b0;
    check("bp_next_grant", grant_id, 3);
    wait_rsp(3);
    check("bp_next_acc", rsp_acc, 93);
    tick();

`ifdef MAC_ARB_TIMEOUT_EN
    mac_hang = 1;
    set_req(0, 1, 2, 2, 1);
    wait_grant(0); req_valid[0] = 1'b0;
    tick();
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 30) begin tick(); n++; end
    check("to_latency", n, 8);
    check("to_err", rsp_err, 1);
    check("to_acc", rsp_acc, 0);
    tick();
    mac_hang = 0; mac_lat = 1;
    set_req(2, 1, 3, 5, 1);
    wait_grant(2); req_valid[2] = 1'b0;
    wait_rsp(2);
    check("to_after_acc", rsp_acc, 15);
    check("to_after_err", rsp_err, 0);
    tick();
`else
    mac_lat = 20;
    set_req(0, 1, 2, 2, 1);
    wait_grant(0); req_valid[0] = 1'b0;
    wait_rsp(0);
    check("slow_acc", rsp_acc, 4);
    check("slow_err", rsp_err, 0);
    tick();
`endif
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
